// File: rtl/multi_port_array.sv
// Shared lookup/scratch table: NUM_PORTS registered read ports, one handshaked write port,
// and a sequential fill engine. Define MULTI_PORT_ARRAY_WR_BYPASS_EN for write-first read bypass.
module multi_port_array #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned INIT_MODE = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init_req,
  output logic                          init_done,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [NUM_PORTS-1:0]          rd_en,
  input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
  output logic [NUM_PORTS-1:0]          rd_valid
);

  localparam int unsigned       DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_init_done;
  logic                r_wr_ready;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_rd_data [NUM_PORTS];
  logic [NUM_PORTS-1:0] r_rd_valid;
  logic [DATA_W-1:0]   w_rd_word [NUM_PORTS];
  logic [DATA_W-1:0]   w_init_val;
  logic                w_ready;
  logic                w_wr_fire;

  // Fill engine: walk every address once, then serve traffic until re-init is requested
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_INIT: begin
        w_cnt_nxt = r_cnt + ADDR_W'(1);
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        w_cnt_nxt = '0;
        if (init_req) begin
          w_state_nxt = S_INIT;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_wr_ready  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_init_done <= (w_state_nxt == S_READY);
      r_wr_ready  <= (w_state_nxt == S_READY);
    end
  end

  assign w_ready    = (r_state == S_READY);
  assign w_wr_fire  = wr_valid & r_wr_ready;
  assign w_init_val = (INIT_MODE == 0) ? DATA_W'(r_cnt) : '0;

  // Storage has no reset; the fill sequence defines its contents
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_cnt] <= w_init_val;
    end else if (w_wr_fire) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rd_word[p] = r_mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef MULTI_PORT_ARRAY_WR_BYPASS_EN
      if (w_wr_fire && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr)) begin
        w_rd_word[p] = wr_data;
      end
`endif
    end
  end

  // Reads are only honoured while the array is ready; data holds otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rd_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rd_valid[p] <= rd_en[p] & w_ready;
        if (rd_en[p] && w_ready) begin
          r_rd_data[p] <= w_rd_word[p];
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_rd_out
      assign rd_data[g*DATA_W +: DATA_W] = r_rd_data[g];
    end
  endgenerate

  assign rd_valid  = r_rd_valid;
  assign init_done = r_init_done;
  assign wr_ready  = r_wr_ready;

endmodule

// File: tb/tb_multi_port_array.sv
// Bench for multi_port_array: directed vector table, fill timing, reset corners and a
// randomized phase checked against an array-based reference model.
module tb_multi_port_array;

`ifdef MULTI_PORT_ARRAY_WR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [7:0] BYPV = BYP ? 8'h55 : 8'h20;
  localparam int NV = 6;

  logic        clk;
  logic        reset;
  logic        init_req;
  logic        init_done;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;

  // Small-geometry instances (DATA_W=4, ADDR_W=6), identity and zero fill
  logic        sz_init_req;
  logic        sz_wr_valid;
  logic [5:0]  sz_wr_addr;
  logic [3:0]  sz_wr_data;
  logic [1:0]  s_rd_en;
  logic [11:0] s_rd_addr;
  logic        s_init_done, z_init_done;
  logic        s_wr_ready, z_wr_ready;
  logic [7:0]  s_rd_data, z_rd_data;
  logic [1:0]  s_rd_valid, z_rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  rd_en;
    logic [31:0] rd_addr;
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs [NV];
  logic [7:0]  model [256];
  logic [31:0] exp_d;
  logic [3:0]  exp_v;

  multi_port_array u_dut (
    .clk(clk), .reset(reset), .init_req(init_req), .init_done(init_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  multi_port_array #(.NUM_PORTS(2), .DATA_W(4), .ADDR_W(6), .INIT_MODE(0)) u_small (
    .clk(clk), .reset(reset), .init_req(sz_init_req), .init_done(s_init_done),
    .wr_valid(sz_wr_valid), .wr_ready(s_wr_ready), .wr_addr(sz_wr_addr), .wr_data(sz_wr_data),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid)
  );

  multi_port_array #(.NUM_PORTS(2), .DATA_W(4), .ADDR_W(6), .INIT_MODE(1)) u_zero (
    .clk(clk), .reset(reset), .init_req(sz_init_req), .init_done(z_init_done),
    .wr_valid(sz_wr_valid), .wr_ready(z_wr_ready), .wr_addr(sz_wr_addr), .wr_data(sz_wr_data),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(z_rd_data), .rd_valid(z_rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until init_done; reads and writes must stay idle throughout the fill
  task automatic wait_ready(input string name, input int exp_cycles);
    int cyc = 0;
    bit bad = 1'b0;
    while (init_done !== 1'b1 && cyc < 400) begin
      if (rd_valid !== 4'h0 || wr_ready !== 1'b0) bad = 1'b1;
      step();
      cyc++;
    end
    check({name, " fill cycles"}, 64'(cyc), 64'(exp_cycles));
    check({name, " idle during fill"}, 64'(bad), 64'd0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " init_done"}, 64'(init_done), 64'd0);
    check({name, " wr_ready"},  64'(wr_ready),  64'd0);
    check({name, " rd_valid"},  64'(rd_valid),  64'd0);
    check({name, " rd_data"},   64'(rd_data),   64'd0);
  endtask

  task automatic model_identity();
    for (int a = 0; a < 256; a++) model[a] = 8'(a);
  endtask

  initial begin
    vecs[0] = '{4'hF, 32'hFFA57F00, 1'b0, 8'h00, 8'h00, 4'hF, 32'hFFA57F00};
    vecs[1] = '{4'h0, 32'h00000000, 1'b1, 8'h10, 8'h3C, 4'h0, 32'hFFA57F00};
    vecs[2] = '{4'hF, 32'h10101010, 1'b0, 8'h00, 8'h00, 4'hF, 32'h3C3C3C3C};
    vecs[3] = '{4'h2, 32'h00002000, 1'b1, 8'h20, 8'h55, 4'h2, {8'h3C, 8'h3C, BYPV, 8'h3C}};
    vecs[4] = '{4'hA, 32'h21002000, 1'b0, 8'h00, 8'h00, 4'hA, 32'h213C553C};
    vecs[5] = '{4'h5, 32'h00100080, 1'b0, 8'h00, 8'h00, 4'h5, 32'h213C5580};

    reset = 1'b0; init_req = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    sz_init_req = 1'b0; sz_wr_valid = 1'b0; sz_wr_addr = '0; sz_wr_data = '0;
    s_rd_en = '0; s_rd_addr = '0;
    repeat (3) step();
    check_reset_vals("reset");

    // Power-on fill with reads requested the whole time
    reset = 1'b1;
    rd_en = 4'hF; rd_addr = 32'h01020304;
    wait_ready("por", 256);
    rd_en = 4'h0;
    check("por wr_ready", 64'(wr_ready), 64'd1);

    // Narrow-data geometry: identity truncates, zero fill is all zero
    s_rd_en = 2'b11; s_rd_addr = {6'h3F, 6'h23};
    step();
    s_rd_en = 2'b00;
    check("small init_done", 64'(s_init_done), 64'd1);
    check("small rd_valid", 64'(s_rd_valid), 64'h3);
    check("small identity data", 64'(s_rd_data), 64'hF3);
    check("zero rd_valid", 64'(z_rd_valid), 64'h3);
    check("zero fill data", 64'(z_rd_data), 64'h00);

    model_identity();
    for (int i = 0; i < NV; i++) begin
      rd_en = vecs[i].rd_en; rd_addr = vecs[i].rd_addr;
      wr_valid = vecs[i].wr_valid; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      step();
      check($sformatf("vec%0d rd_valid", i), 64'(rd_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d rd_data", i), 64'(rd_data), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d wr_ready", i), 64'(wr_ready), 64'd1);
      if (vecs[i].wr_valid) model[vecs[i].wr_addr] = vecs[i].wr_data;
    end
    rd_en = '0; wr_valid = 1'b0;
    exp_d = vecs[NV-1].exp_data;

    // Random traffic on a narrow address window to force collisions
    for (int c = 0; c < 400; c++) begin
      rd_en = 4'($urandom);
      for (int p = 0; p < 4; p++) rd_addr[p*8 +: 8] = 8'($urandom_range(0, 15));
      wr_valid = 1'($urandom);
      wr_addr  = 8'($urandom_range(0, 15));
      wr_data  = 8'($urandom);
      exp_v = rd_en;
      for (int p = 0; p < 4; p++) begin
        if (rd_en[p]) begin
          if (BYP && wr_valid && rd_addr[p*8 +: 8] == wr_addr) exp_d[p*8 +: 8] = wr_data;
          else exp_d[p*8 +: 8] = model[rd_addr[p*8 +: 8]];
        end
      end
      if (wr_valid) model[wr_addr] = wr_data;
      step();
      check($sformatf("rand%0d rd_valid", c), 64'(rd_valid), 64'(exp_v));
      check($sformatf("rand%0d rd_data", c), 64'(rd_data), 64'(exp_d));
    end
    rd_en = '0; wr_valid = 1'b0;

    // Re-init together with a write; a write held through the fill must be ignored
    init_req = 1'b1; wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 8'h99;
    step();
    init_req = 1'b0; wr_addr = 8'h06; wr_data = 8'hEE;
    check("reinit init_done fall", 64'(init_done), 64'd0);
    wait_ready("reinit", 256);
    wr_valid = 1'b0;
    model_identity();
    rd_en = 4'h3; rd_addr = 32'h00000605;
    step();
    rd_en = 4'h0;
    exp_d[15:0] = 16'h0605;
    check("reinit rd_valid", 64'(rd_valid), 64'h3);
    check("reinit rd_data", 64'(rd_data), 64'(exp_d));

    // Reset with a read in flight in READY, then again mid-fill at cnt = 100
    rd_en = 4'hF; rd_addr = 32'h40302010;
    step();
    check("pre-reset rd_valid", 64'(rd_valid), 64'hF);
    reset = 1'b0;
    #1;
    check_reset_vals("reset ready");
    step(); step();
    reset = 1'b1;
    repeat (100) step();
    check("mid-fill init_done", 64'(init_done), 64'd0);
    reset = 1'b0;
    #1;
    check_reset_vals("reset fill");
    step();
    reset = 1'b1;
    wait_ready("after reset", 256);
    rd_en = 4'hF; rd_addr = 32'h20100A03;
    step();
    rd_en = 4'h0;
    check("post-reset rd_valid", 64'(rd_valid), 64'hF);
    check("post-reset rd_data", 64'(rd_data), 64'h20100A03);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_port_array.md
Name: multi_port_array

Overview:
- Parametrised successor of the fixed 4-port identity lookup array: NUM_PORTS registered read ports, one handshaked write port, and a sequential init engine.
- The init engine fills the array after reset or on request, instead of loading every word at once.
- Serves as a shared lookup/scratch table for multiple cores; each core owns one read port, and a single arbiter upstream drives the write port.

Parameters:
- NUM_PORTS, 4, number of independent read ports (1..8)
- DATA_W, 8, word width in bits
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- INIT_MODE, 0, 0 = identity fill (word i <= i mod 2**DATA_W); 1 = zero fill

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- init_req  in  1  pulse in READY state restarts the fill sequence
- init_done  out  1  high while array is READY
- wr_valid  in  1  write request
- wr_ready  out  1  write can be accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_en  in  NUM_PORTS  per-port read strobe
- rd_addr  in  NUM_PORTS*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_PORTS*DATA_W  port p data at bits [p*DATA_W +: DATA_W]
- rd_valid  out  NUM_PORTS  per-port read data valid

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to INIT; init counter = 0.
  - init_done = 0, wr_ready = 0, rd_valid = 0, rd_data = 0.
  - Array contents are not reset directly; the fill sequence defines them.
- States: INIT, READY.
- INIT:
  - Each cycle writes word[cnt] = (INIT_MODE==0 ? cnt[DATA_W-1:0] : 0), then cnt++.
  - When cnt == DEPTH-1 is written, go to READY next cycle. INIT therefore lasts exactly DEPTH cycles after reset release.
  - When DATA_W < ADDR_W, the identity value wraps (truncates).
- READY:
  - init_done = 1, wr_ready = 1.
  - init_req = 1 goes to INIT next cycle with cnt = 0.
- INIT takes priority over the external port:
  - In INIT, wr_ready = 0; wr_valid is ignored and the requester must hold its request.
  - In INIT, rd_en is ignored and rd_valid stays 0.
- Write:
  - A write is accepted when wr_valid & wr_ready at a rising edge.
  - word[wr_addr] updates at that edge.
- Simultaneous init_req and an accepted write in READY: the write commits, then INIT starts next cycle and overwrites it.
- Read port p:
  - If rd_en[p] at edge N (state READY), rd_data[p] holds word[rd_addr[p]] and rd_valid[p] = 1 after edge N (1-cycle latency).
  - Otherwise rd_valid[p] = 0 and rd_data[p] holds its last value.
- Read-during-write, same address, same edge: read returns the OLD word (see optional feature).
- Multiple ports may read the same address in the same cycle; all receive identical data, with no conflicts or stalls.
- Reset asserted mid-INIT or mid-READY:
  - Immediate return to reset values.
  - Fill restarts from 0 after release.
  - Any read in flight is discarded (rd_valid = 0).

Optional Feature:
- Macro: MULTI_PORT_ARRAY_WR_BYPASS_EN.
- Defined: a read on the same address as a write accepted in the same cycle returns wr_data (write-first bypass) on that port.
- Not defined: the read returns the pre-write word (read-first). There is no bypass logic.
- All other behaviour is identical.

Test Plan:
- Reset release, INIT_MODE=0, defaults -> init_done rises exactly 256 cycles after release. Then read ports 0..3 at addrs 0x00, 0x7F, 0xA5, 0xFF -> data 0x00, 0x7F, 0xA5, 0xFF, rd_valid 1 cycle later.
- INIT_MODE=0, DATA_W=4, ADDR_W=6:
  - Reading addr 0x23 returns 0x3.
  - INIT_MODE=1: any addr returns 0.
- Write 0x3C to addr 0x10, then read 0x10 on all 4 ports in the same cycle -> all return 0x3C. wr_ready stays 1 in READY.
- Write 0x55 to addr 0x20 while port 1 reads 0x20 in the same cycle:
  - Without macro -> 0x20.
  - With MULTI_PORT_ARRAY_WR_BYPASS_EN -> 0x55.
  - The next read always returns 0x55.
- init_req pulse together with a write of 0x99 to addr 5 -> init_done falls next cycle and wr_ready = 0 for 256 cycles. Afterwards addr 5 reads 0x05.
- Assert reset at cnt = 100 during INIT, release -> outputs at reset values. init_done rises 256 cycles after the second release. Reads during INIT give rd_valid = 0.
